pce_pixel_capture: RTL and testbench

Downstream consumer of the HuC6260 VCE video output. Samples the VCE's 3-bit-per-channel RGB on a per-pixel strobe and tracks the HSYNC_n/VSYNC_n edges to compute (x, y) coordinates inside a programmable capture window. Each captured pixel is pushed through a small FIFO to a framebuffer write port that uses a valid/ready handshake. It is the first stage of the HD output path: VDC → VCE → pce_pixel_capture → framebuffer.

---
 rtl/pce_pixel_capture.sv | 209 ++++++++++++++++++++
 tb/tb_pce_pixel_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pce_pixel_capture.sv
// pce_pixel_capture: samples HuC6260 VCE RGB on pix_en, tracks HSYNC_n/VSYNC_n edges,
//   pushes in-window pixels with their {y, x} address to a framebuffer write port.
// Latency: sync edges act in the cycle they are sampled; a pixel reaches wr_valid the
//   cycle after its pix_en when the FIFO was empty.
// Backpressure: wr_ready stalls the FIFO head; pixels offered while full (and not
//   popping) are dropped and set the sticky overflow flag.
//
// Ports: clock/reset (async, active-high); pix_en, HSYNC_n, VSYNC_n, VIDEO_R/G/B from
//   the VCE; wr_valid/wr_ready/wr_addr/wr_data framebuffer write port; frame_done,
//   frame_count, overflow status.
// Optional build macro PCE_CAPTURE_RGB888_EN: wr_data widens to 24-bit {R8,G8,B8}
//   by bit replication; otherwise wr_data is the raw 9-bit {R,G,B}.

// pce_fifo: generic synchronous FIFO with first-word fall-through read port.
// Latency: an entry written in cycle N is visible on out_vld/out_dat in cycle N+1.
// Backpressure: full blocks a push unless the same cycle pops; out_rdy pops the head.
module pce_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign out_vld = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = out_vld && out_rdy;
  assign do_push = in_vld && (!full || do_pop);
  // Stale storage is hidden so the port reads zero whenever nothing is valid.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pce_pixel_capture #(
  parameter int H_START    = 0,
  parameter int H_ACTIVE   = 256,
  parameter int V_START    = 14,
  parameter int V_ACTIVE   = 242,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        HSYNC_n,
  input  logic        VSYNC_n,
  input  logic [2:0]  VIDEO_R,
  input  logic [2:0]  VIDEO_G,
  input  logic [2:0]  VIDEO_B,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [17:0] wr_addr,
`ifdef PCE_CAPTURE_RGB888_EN
  output logic [23:0] wr_data,
`else
  output logic [8:0]  wr_data,
`endif
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        overflow
);
  localparam logic [9:0] HS    = 10'(H_START);
  localparam logic [9:0] HS_M1 = 10'(H_START - 1);
  localparam logic [9:0] HA_M1 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] VS    = 10'(V_START);
  localparam logic [9:0] V_END = 10'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {IDLE, LINE_WAIT, H_SKIP, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic        hs_fall, vs_fall;
  logic [9:0]  line_cnt, pix_cnt;
  logic [8:0]  y_q, y_d;
  logic [8:0]  cap_x;
  logic        capture;
  logic        in_window;
  logic        fifo_push, fifo_full, drop;
  logic [26:0] fifo_in, fifo_out;

  assign hs_fall   = !HSYNC_n && hs_q;
  assign vs_fall   = !VSYNC_n && vs_q;
  // Window test uses the line count before this hs_fall increments it.
  assign in_window = (line_cnt >= VS) && (line_cnt < V_END);

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    cap_x      = 9'(pix_cnt - HS);
    if (vs_fall) begin
      // A coincident hs_fall is swallowed: the frame restarts at line 0.
      state_d = LINE_WAIT;
    end else if (hs_fall) begin
      if (state_q != IDLE) begin
        frame_done = (line_cnt == V_END);
        if (in_window) begin
          y_d = 9'(line_cnt - VS);
          if (H_START == 0) state_d = ACTIVE;
          else              state_d = H_SKIP;
        end else begin
          state_d = LINE_WAIT;
        end
      end
    end else if (pix_en) begin
      case (state_q)
        H_SKIP: if (pix_cnt == HS_M1) state_d = ACTIVE;
        ACTIVE: begin
          capture = 1'b1;
          if (10'(pix_cnt - HS) == HA_M1) state_d = LINE_WAIT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      line_cnt    <= '0;
      pix_cnt     <= '0;
      y_q         <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hs_q    <= HSYNC_n;
      vs_q    <= VSYNC_n;

      if (vs_fall)                              line_cnt <= '0;
      else if (hs_fall && line_cnt != 10'h3FF)  line_cnt <= line_cnt + 1'b1;

      // Saturating so a very long line cannot wrap back into H_SKIP's match value.
      if (hs_fall)                              pix_cnt <= '0;
      else if (pix_en && pix_cnt != 10'h3FF)    pix_cnt <= pix_cnt + 1'b1;

      if (frame_done) frame_count <= frame_count + 1'b1;

      // A drop in the same cycle as vs_fall still leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (vs_fall) overflow <= 1'b0;
    end
  end

  // Pushing into a full FIFO is fine when the head leaves in the same cycle.
  assign fifo_push = capture && (!fifo_full || (wr_valid && wr_ready));
  assign drop      = capture && !fifo_push;
  assign fifo_in   = {y_q, cap_x, VIDEO_R, VIDEO_G, VIDEO_B};

  pce_fifo #(
    .W     (27),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (fifo_push),
    .in_dat  (fifo_in),
    .out_rdy (wr_ready),
    .out_vld (wr_valid),
    .out_dat (fifo_out),
    .full    (fifo_full)
  );

  assign wr_addr = fifo_out[26:9];
`ifdef PCE_CAPTURE_RGB888_EN
  assign wr_data = {fifo_out[8:6], fifo_out[8:6], fifo_out[8:7],
                    fifo_out[5:3], fifo_out[5:3], fifo_out[5:4],
                    fifo_out[2:0], fifo_out[2:0], fifo_out[2:1]};
`else
  assign wr_data = fifo_out[8:0];
`endif
endmodule

// File: tb/tb_pce_pixel_capture.sv
module tb_pce_pixel_capture;
`ifdef PCE_CAPTURE_RGB888_EN
  localparam int DW = 24;
  localparam logic [23:0] EXP_COL = 24'hFF00B6;
`else
  localparam int DW = 9;
  localparam logic [8:0] EXP_COL = 9'h1C5;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          pix_en, hsync_n, vsync_n, wr_ready;
  logic [2:0]    video_r, video_g, video_b;
  logic          wr_valid, frame_done, overflow;
  logic [17:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   frame_count;

  int vecs = 0;
  int errs = 0;
  int fd_cnt = 0;
  logic [17:0]   addr_q[$];
  logic [DW-1:0] data_q[$];

  always #5 clock = ~clock;

  pce_pixel_capture #(
    .H_START(0), .H_ACTIVE(256), .V_START(14), .V_ACTIVE(4), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .HSYNC_n(hsync_n), .VSYNC_n(vsync_n),
    .VIDEO_R(video_r), .VIDEO_G(video_g), .VIDEO_B(video_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
  );

  // Log every accepted write and every frame_done cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_valid && wr_ready) begin
        addr_q.push_back(wr_addr);
        data_q.push_back(wr_data);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One line: a single-cycle hs low, one quiet cycle, then n back-to-back strobes.
  task automatic line(input int n);
    pix_en = 1'b0; hsync_n = 1'b0; step();
    hsync_n = 1'b1; step();
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b1; step();
    end
    pix_en = 1'b0;
  endtask

  task automatic vsync();
    pix_en = 1'b0; vsync_n = 1'b0; step();
    vsync_n = 1'b1; step();
  endtask

  task automatic clear_log();
    addr_q.delete();
    data_q.delete();
  endtask

  // Expect log entries [first, first+n) to be row y, columns x0, x0+1, ...
  task automatic chk_run(input string tag, input int first, input int n,
                         input int y, input int x0);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [17:0] e;
      e = {9'(y), 9'(x0 + i)};
      if (first + i >= addr_q.size()) bad++;
      else if (addr_q[first + i] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; wr_ready = 1'b1;
    video_r = 3'd7; video_g = 3'd0; video_b = 3'd5;
    step(3);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    step(2);

    // Full frame: 20 lines x 300 strobes, lines 14..17 captured at 256 pixels each.
    clear_log(); fd_cnt = 0;
    vsync();
    for (int l = 0; l < 20; l++) line(300);
    step(4);
    chk("frame_writes", addr_q.size(), 1024);
    chk("frame_first_addr", addr_q.size() > 0 ? addr_q[0] : 18'h3FFFF, 18'h0);
    chk("frame_last_addr", addr_q.size() > 1023 ? addr_q[1023] : 18'h3FFFF, 18'h006FF);
    chk("frame_first_data", data_q.size() > 0 ? 32'(data_q[0]) : 32'hDEAD, 32'(EXP_COL));
    for (int y = 0; y < 4; y++) chk_run("frame_addr_seq", y * 256, 256, y, 0);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("frame_count_1", frame_count, 1);
    chk("frame_no_overflow", overflow, 0);

    // Stalled sink for a whole line: only the first 8 pixels survive.
    vsync();
    for (int l = 0; l < 14; l++) line(2);
    wr_ready = 1'b0;
    line(300);
    step(2);
    chk("stall_overflow", overflow, 1);
    chk("stall_wr_valid", wr_valid, 1);
    chk("stall_head_addr", wr_addr, 18'h0);
    clear_log();
    wr_ready = 1'b1;
    step(12);
    chk("stall_kept", addr_q.size(), 8);
    chk_run("stall_kept_seq", 0, 8, 0, 0);
    chk("stall_drained", wr_valid, 0);
    line(5);
    step(3);
    chk("overflow_sticky", overflow, 1);
    vsync();
    chk("overflow_cleared", overflow, 0);
    chk("cut_frame_no_count", frame_count, 1);

    // Coincident hs/vs fall must not count as a line; then an early-ended line.
    clear_log(); fd_cnt = 0;
    pix_en = 1'b0; hsync_n = 1'b0; vsync_n = 1'b0; step();
    hsync_n = 1'b1; vsync_n = 1'b1; step();
    for (int l = 0; l < 14; l++) line(5);
    step(3);
    chk("coinc_no_write", addr_q.size(), 0);
    line(5);
    line(100);
    line(10);
    line(3);
    line(0);
    step(3);
    chk("short_lines_writes", addr_q.size(), 118);
    chk_run("short_y0", 0, 5, 0, 0);
    chk_run("short_y1", 5, 100, 1, 0);
    chk_run("short_y2", 105, 10, 2, 0);
    chk_run("short_y3", 115, 3, 3, 0);
    chk("short_frame_done", fd_cnt, 1);
    chk("frame_count_2", frame_count, 2);

    // Asynchronous reset with 5 pixels queued.
    vsync();
    for (int l = 0; l < 14; l++) line(2);
    wr_ready = 1'b0;
    line(5);
    step(2);
    chk("pre_reset_valid", wr_valid, 1);
    clear_log();
    #3 reset = 1'b1;
    #1;
    chk("async_reset_valid", wr_valid, 0);
    chk("async_reset_overflow", overflow, 0);
    chk("async_reset_count", frame_count, 0);
    step();
    reset = 1'b0;
    wr_ready = 1'b1;
    step(2);
    for (int l = 0; l < 20; l++) line(5);
    step(3);
    chk("idle_no_write", addr_q.size(), 0);
    vsync();
    for (int l = 0; l < 14; l++) line(5);
    step(3);
    chk("vstart_no_write", addr_q.size(), 0);
    line(5);
    step(3);
    chk("post_reset_writes", addr_q.size(), 5);
    chk_run("post_reset_seq", 0, 5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
